// File: rtl/ms_timer_scheduler.sv
// Shared millisecond prescaler driving CH independent countdown timers.
// A single tick_ms enable strobe paces all channels; there are no derived clocks.
module ms_timer_scheduler #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned CH       = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CH-1:0]       start,
    input  logic [CH-1:0]       cancel,
    input  logic [CH*CNT_W-1:0] load_ms,
    output logic                tick_ms,
    output logic [CH-1:0]       busy,
    output logic [CH-1:0]       done,
    output logic [CH*CNT_W-1:0] remaining
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] rem_q [CH];
    logic [CNT_W-1:0] rem_d [CH];
    logic [CH-1:0]    busy_q, busy_d;
    logic [CH-1:0]    done_q, done_d;

    // Prescaler phase is held (not cleared) while enable is low.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (enable) begin
            if (presc_q == PrescLast) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Per channel: cancel beats start beats decrement; the load edge ignores tick.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            rem_d[i]  = rem_q[i];
            busy_d[i] = busy_q[i];
            done_d[i] = 1'b0;
            if (cancel[i]) begin
                rem_d[i]  = '0;
                busy_d[i] = 1'b0;
            end else if (start[i]) begin
                if (load_ms[i*CNT_W +: CNT_W] != '0) begin
                    rem_d[i]  = load_ms[i*CNT_W +: CNT_W];
                    busy_d[i] = 1'b1;
                end else begin
                    rem_d[i]  = '0;
                    busy_d[i] = 1'b0;
                    done_d[i] = 1'b1;
                end
            end else if (busy_q[i] && tick_q && (rem_q[i] != '0)) begin
                if (rem_q[i] == CNT_W'(1)) begin
                    rem_d[i]  = '0;
                    busy_d[i] = 1'b0;
                    done_d[i] = 1'b1;
                end else begin
                    rem_d[i] = rem_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            busy_q  <= '0;
            done_q  <= '0;
            for (int i = 0; i < CH; i++) begin
                rem_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < CH; i++) begin
                rem_q[i] <= rem_d[i];
            end
        end
    end

    always_comb begin
        remaining = '0;
        for (int i = 0; i < CH; i++) begin
            remaining[i*CNT_W +: CNT_W] = rem_q[i];
        end
    end

    assign tick_ms = tick_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// Self-checking bench for ms_timer_scheduler: done pulses are predicted at start
// time into a scoreboard and matched by a monitor against the edge they appear on.
module tb_ms_timer_scheduler;

    localparam int P  = 4;
    localparam int CH = 4;
    localparam int W  = 16;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [CH-1:0]   start;
    logic [CH-1:0]   cancel;
    logic [CH*W-1:0] load_ms;
    logic            tick_ms;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;
    logic [CH*W-1:0] remaining;

    ms_timer_scheduler #(.PRESCALE(P), .CH(CH), .CNT_W(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .start     (start),
        .cancel    (cancel),
        .load_ms   (load_ms),
        .tick_ms   (tick_ms),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    typedef struct {
        int ch;
        int e;
    } exp_t;
    exp_t sb[$];

    // Rising edges since reset release; DUT outputs are sampled on falling edges.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edge_n <= 0;
        else          edge_n <= edge_n + 1;
    end

    // Ticks are consumed on edges k*P+1; this is the first one after the load edge s.
    function automatic int first_consume(input int s);
        return P * ((s - 1) / P) + P + 1;
    endfunction

    function automatic int done_edge(input int s, input int l);
        if (l == 0) return s;
        return first_consume(s) + P * (l - 1);
    endfunction

    function automatic int exp_rem(input int s, input int l, input int e);
        int c1;
        int n;
        if (l == 0) return 0;
        c1 = first_consume(s);
        n  = (e < c1) ? 0 : (e - c1) / P + 1;
        return (n >= l) ? 0 : l - n;
    endfunction

    always @(negedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < CH; i++) begin
                if (done[i] === 1'b1) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++) begin
                        if (idx < 0 && sb[k].ch == i) idx = k;
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL unexpected_done ch=%0d edge=%0d got=1 want=0", i, edge_n);
                    end else begin
                        if (sb[idx].e != edge_n) begin
                            errors++;
                            $display("FAIL done_time ch=%0d got_edge=%0d want_edge=%0d",
                                     i, edge_n, sb[idx].e);
                        end
                        sb.delete(idx);
                    end
                end
            end
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].e < edge_n) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_done ch=%0d want_edge=%0d now=%0d",
                             sb[k].ch, sb[k].e, edge_n);
                    sb.delete(k);
                end
            end
        end
    end

    // Drives a one-edge start; returns the edge that samples it and leaves time on
    // the falling edge right after that edge.
    task automatic do_start(input int ch, input int l, input bit push, output int s);
        exp_t x;
        start[ch]            = 1'b1;
        load_ms[ch*W +: W]   = W'(l);
        s                    = edge_n + 1;
        if (push) begin
            x.ch = ch;
            x.e  = done_edge(s, l);
            sb.push_back(x);
        end
        @(negedge clock);
        start[ch] = 1'b0;
    endtask

    task automatic check_ch(input int ch, input int s, input int l, input int last_e);
        int r;
        while (1) begin
            r = exp_rem(s, l, edge_n);
            checks++;
            if (remaining[ch*W +: W] !== W'(r) || busy[ch] !== (r > 0)) begin
                errors++;
                $display("FAIL count ch=%0d edge=%0d got rem=%0d busy=%b want rem=%0d busy=%b",
                         ch, edge_n, remaining[ch*W +: W], busy[ch], r, (r > 0));
            end
            if (edge_n >= last_e) break;
            @(negedge clock);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got_pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        checks++;
        if (tick_ms !== 1'b0 || busy !== '0 || done !== '0 || remaining !== '0) begin
            errors++;
            $display("FAIL reset_state got tick=%b busy=%b done=%b rem=%h want all 0",
                     tick_ms, busy, done, remaining);
        end
    endtask

    task automatic test_tick(input int n_edges);
        for (int k = 0; k < n_edges; k++) begin
            @(negedge clock);
            checks++;
            if (tick_ms !== (edge_n % P == 0) || busy !== '0 || done !== '0) begin
                errors++;
                $display("FAIL tick edge=%0d got tick=%b busy=%b done=%b want tick=%b busy=0 done=0",
                         edge_n, tick_ms, busy, done, (edge_n % P == 0));
            end
        end
    endtask

    task automatic test_load_on_tick();
        int s;
        while (edge_n % P != 0) @(negedge clock);
        do_start(0, 3, 1'b1, s);
        check_ch(0, s, 3, done_edge(s, 3) + 1);
        wait_drain(8);
    endtask

    task automatic test_zero_load();
        int s;
        do_start(1, 0, 1'b1, s);
        check_ch(1, s, 0, s + 3);
        wait_drain(4);
    endtask

    task automatic test_cancel_start();
        int s;
        do_start(2, 5, 1'b0, s);
        check_ch(2, s, 5, first_consume(s) + P);
        cancel[2]       = 1'b1;
        start[2]        = 1'b1;
        load_ms[2*W +: W] = W'(7);
        @(negedge clock);
        cancel[2] = 1'b0;
        start[2]  = 1'b0;
        repeat (12) begin
            checks++;
            if (busy[2] !== 1'b0 || remaining[2*W +: W] !== '0) begin
                errors++;
                $display("FAIL cancel_start edge=%0d got busy=%b rem=%0d want busy=0 rem=0",
                         edge_n, busy[2], remaining[2*W +: W]);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_cancel_at_expiry();
        int s;
        int d;
        do_start(1, 1, 1'b0, s);
        d = done_edge(s, 1);
        while (edge_n < d - 1) @(negedge clock);
        cancel[1] = 1'b1;
        @(negedge clock);
        cancel[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b0 || remaining[1*W +: W] !== '0 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL cancel_expiry got busy=%b rem=%0d done=%b want 0 0 0",
                     busy[1], remaining[1*W +: W], done[1]);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        exp_t x;
        do_start(0, 5, 1'b0, s1);
        while (edge_n < first_consume(s1)) @(negedge clock);
        do_start(0, 2, 1'b1, s2);
        check_ch(0, s2, 2, done_edge(s2, 2) + 1);
        wait_drain(4);
        // Two channels expiring on the same edge.
        start             = 4'b0011;
        load_ms[0*W +: W] = W'(2);
        load_ms[1*W +: W] = W'(2);
        s1                = edge_n + 1;
        x.ch = 0; x.e = done_edge(s1, 2); sb.push_back(x);
        x.ch = 1; x.e = done_edge(s1, 2); sb.push_back(x);
        @(negedge clock);
        start = '0;
        wait_drain(20);
    endtask

    task automatic test_pause();
        int s;
        int r;
        exp_t x;
        do_start(3, 4, 1'b0, s);
        @(negedge clock);
        while (edge_n % P != 2) @(negedge clock);
        x.ch = 3;
        x.e  = done_edge(s, 4) + 20;
        sb.push_back(x);
        r      = exp_rem(s, 4, edge_n);
        enable = 1'b0;
        repeat (20) begin
            @(negedge clock);
            checks++;
            if (tick_ms !== 1'b0 || remaining[3*W +: W] !== W'(r) || busy[3] !== 1'b1) begin
                errors++;
                $display("FAIL pause edge=%0d got tick=%b rem=%0d busy=%b want tick=0 rem=%0d busy=1",
                         edge_n, tick_ms, remaining[3*W +: W], busy[3], r);
            end
        end
        enable = 1'b1;
        wait_drain(40);
        checks++;
        if (busy[3] !== 1'b0) begin
            errors++;
            $display("FAIL pause_busy got=%b want=0", busy[3]);
        end
    endtask

    task automatic test_async_reset();
        int s;
        do_start(0, 10, 1'b0, s);
        do_start(1, 10, 1'b0, s);
        repeat (5) @(negedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        test_reset();
        sb.delete();
        repeat (2) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        test_tick(8);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        start   = '0;
        cancel  = '0;
        load_ms = '0;
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        test_tick(12);
        test_load_on_tick();
        test_zero_load();
        test_cancel_start();
        test_cancel_at_expiry();
        test_back_to_back();
        test_pause();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
